// File: rtl/rdma_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rdma_stream_arbiter
//   Packet-granular round-robin arbiter that shares the single AXI-Stream input
//   of the RDMA parser between NUM_PORTS upstream sources. The grant is locked
//   from the first beat of a packet until its tlast handshake, so packets from
//   different sources are never interleaved.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   i_port_en       per-source enable mask (sampled only while arbitrating)
//   i_s_data/keep   packed source data / byte enables, port i at slice i
//   i_s_valid/last  per-source valid / end-of-packet
//   o_s_ready       per-source ready (only the locked source can be ready)
//   o_m_*           stream towards the parser (combinational mux, no buffering)
//   i_m_ready       parser ready
//   o_grant_id      index of the locked source
//   o_busy          high while a packet is locked
//   o_pkt_done      one-cycle pulse after each forwarded last beat
//   o_pkt_count     free-running count of forwarded packets (wraps)
// -----------------------------------------------------------------------------
module rdma_stream_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = 8,
    parameter int ID_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        i_port_en,
    input  logic [NUM_PORTS*DATA_W-1:0] i_s_data,
    input  logic [NUM_PORTS*KEEP_W-1:0] i_s_keep,
    input  logic [NUM_PORTS-1:0]        i_s_valid,
    input  logic [NUM_PORTS-1:0]        i_s_last,
    output logic [NUM_PORTS-1:0]        o_s_ready,
    output logic [DATA_W-1:0]           o_m_data,
    output logic [KEEP_W-1:0]           o_m_keep,
    output logic                        o_m_valid,
    output logic                        o_m_last,
    input  logic                        i_m_ready,
    output logic [ID_W-1:0]             o_grant_id,
    output logic                        o_busy,
    output logic                        o_pkt_done,
    output logic [31:0]                 o_pkt_count
);

    // One-hot state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_LOCK = 2'b10
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_busy;
    logic              r_pkt_done;
    logic [31:0]       r_pkt_count;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_any_req;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W-1:0]      w_idx;
    logic                 w_locked;
    logic                 w_last_hs;

    logic [DATA_W-1:0] w_data [NUM_PORTS];
    logic [KEEP_W-1:0] w_keep [NUM_PORTS];

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_unpack
            assign w_data[g] = i_s_data[g*DATA_W +: DATA_W];
            assign w_keep[g] = i_s_keep[g*KEEP_W +: KEEP_W];
        end
    endgenerate

    assign w_req     = i_s_valid & i_port_en;
    assign w_locked  = (r_state == ST_LOCK);
    assign w_last_hs = w_locked & i_s_valid[r_grant_id] & i_s_last[r_grant_id] & i_m_ready;

    // Round-robin winner search starting just after the last granted port.
    // Scanning from the farthest offset down leaves the nearest requester as winner.
    always_comb begin
        w_any_req = 1'b0;
        w_winner  = '0;
        w_idx     = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
            if (w_req[w_idx]) begin
                w_any_req = 1'b1;
                w_winner  = w_idx;
            end else begin
                w_winner  = w_winner;
            end
        end
    end

    // Zero-latency datapath mux; handshake signals are forced low outside LOCK
    // and while reset is asserted.
    always_comb begin
        o_m_data  = w_data[r_grant_id];
        o_m_keep  = w_keep[r_grant_id];
        o_m_last  = 1'b0;
        o_m_valid = 1'b0;
        o_s_ready = '0;
        if (w_locked && !rst) begin
            o_m_last              = i_s_last[r_grant_id];
            o_m_valid             = i_s_valid[r_grant_id];
            o_s_ready[r_grant_id] = i_m_ready;
        end else begin
            o_m_last  = 1'b0;
            o_m_valid = 1'b0;
            o_s_ready = '0;
        end
    end

    // Arbitration FSM with its registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= ID_W'(NUM_PORTS - 1);
            r_busy      <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_count <= 32'd0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ST_LOCK;
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= w_winner;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    // The grant is held through source stalls until the last beat.
                    if (w_last_hs) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_pkt_done  <= 1'b1;
                        r_pkt_count <= r_pkt_count + 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant_id  = r_grant_id;
    assign o_busy      = r_busy;
    assign o_pkt_done  = r_pkt_done;
    assign o_pkt_count = r_pkt_count;

endmodule
